// File: rtl/motor_sequencer.sv
// H-bridge motor sequencer: soft-start ramp, dead-time on reversal/stop,
// filtered overcurrent trip with a cooldown that needs an enable toggle to rearm.
module motor_sequencer #(
    parameter int unsigned DEADTIME_CYCLES = 100000,
    parameter int unsigned RAMP_CYCLES     = 200000,
    parameter logic [11:0] OC_THRESHOLD    = 12'd2000,
    parameter int unsigned OC_FILTER       = 16,
    parameter int unsigned COOLDOWN_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_en,
    input  logic        cmd_dir,
    input  logic [5:0]  cmd_speed,
    input  logic [11:0] current_value,
    input  logic        current_valid,
    output logic        drive_en,
    output logic        drive_dir,
    output logic [5:0]  drive_duty,
    output logic        fault,
    output logic [3:0]  fault_count,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BRAKE = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam int DEAD_W = $clog2(DEADTIME_CYCLES + 1);
    localparam int RAMP_W = $clog2(RAMP_CYCLES + 1);
    localparam int COOL_W = $clog2(COOLDOWN_CYCLES + 1);

    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME_CYCLES - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_CYCLES - 1);
    localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN_CYCLES - 1);
    localparam logic [4:0]        OC_LAST   = 5'(OC_FILTER - 1);

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [4:0] sat_inc5(input logic [4:0] v);
        return (v == 5'h1F) ? v : v + 5'd1;
    endfunction

    state_t              cur_state;
    logic [DEAD_W-1:0]   dead_cnt;
    logic [RAMP_W-1:0]   ramp_cnt;
    logic [COOL_W-1:0]   cool_cnt;
    logic [4:0]          oc_cnt;

    logic oc_active;
    logic oc_over;
    logic oc_trip;

    assign state = cur_state;

    // The sample that completes the filter trips in the same cycle it arrives,
    // so FAULT pre-empts any BRAKE/RUN decision taken on that edge.
    always_comb begin
        oc_active = (cur_state == RUN) || (cur_state == BRAKE);
        oc_over   = (current_value >= OC_THRESHOLD);
        oc_trip   = oc_active && current_valid && oc_over && (oc_cnt >= OC_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset || !oc_active || oc_trip) begin
            oc_cnt <= '0;
        end else if (current_valid) begin
            oc_cnt <= oc_over ? sat_inc5(oc_cnt) : 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state   <= IDLE;
            drive_en    <= 1'b0;
            drive_dir   <= 1'b0;
            drive_duty  <= '0;
            fault       <= 1'b0;
            fault_count <= '0;
            dead_cnt    <= '0;
            ramp_cnt    <= '0;
            cool_cnt    <= '0;
        end else if (oc_trip) begin
            cur_state   <= FAULT;
            drive_en    <= 1'b0;
            drive_duty  <= '0;
            fault       <= 1'b1;
            fault_count <= sat_inc4(fault_count);
            cool_cnt    <= '0;
            dead_cnt    <= '0;
            ramp_cnt    <= '0;
        end else begin
            case (cur_state)
                IDLE: begin
                    drive_en   <= 1'b0;
                    drive_duty <= '0;
                    fault      <= 1'b0;
                    dead_cnt   <= '0;
                    ramp_cnt   <= '0;
                    cool_cnt   <= '0;
                    if (cmd_en) begin
                        cur_state <= RUN;
                        drive_en  <= 1'b1;
                        drive_dir <= cmd_dir;
                    end
                end
                RUN: begin
                    if (!cmd_en || (cmd_dir != drive_dir)) begin
                        cur_state  <= BRAKE;
                        drive_duty <= '0;
                        dead_cnt   <= '0;
                        ramp_cnt   <= '0;
                    end else if (cmd_speed > drive_duty) begin
                        if (ramp_cnt == RAMP_LAST) begin
                            drive_duty <= drive_duty + 6'd1;
                            ramp_cnt   <= '0;
                        end else begin
                            ramp_cnt <= ramp_cnt + RAMP_W'(1);
                        end
                    end else begin
                        drive_duty <= cmd_speed;
                        ramp_cnt   <= '0;
                    end
                end
                BRAKE: begin
                    drive_duty <= '0;
                    // Only the command present at expiry matters; changes inside
                    // the dead-time never restart it.
                    if (dead_cnt == DEAD_LAST) begin
                        dead_cnt <= '0;
                        ramp_cnt <= '0;
                        if (cmd_en) begin
                            cur_state <= RUN;
                            drive_en  <= 1'b1;
                            drive_dir <= cmd_dir;
                        end else begin
                            cur_state <= IDLE;
                            drive_en  <= 1'b0;
                        end
                    end else begin
                        dead_cnt <= dead_cnt + DEAD_W'(1);
                    end
                end
                FAULT: begin
                    drive_en   <= 1'b0;
                    drive_duty <= '0;
                    if (cool_cnt == COOL_LAST) begin
                        if (!cmd_en) begin
                            cur_state <= IDLE;
                            fault     <= 1'b0;
                            cool_cnt  <= '0;
                        end
                    end else begin
                        cool_cnt <= cool_cnt + COOL_W'(1);
                    end
                end
                default: cur_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motor_sequencer.sv
// Directed bench for motor_sequencer with short timing parameters.
module tb_motor_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_en;
    logic        cmd_dir;
    logic [5:0]  cmd_speed;
    logic [11:0] current_value;
    logic        current_valid;
    logic        drive_en;
    logic        drive_dir;
    logic [5:0]  drive_duty;
    logic        fault;
    logic [3:0]  fault_count;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    motor_sequencer #(
        .DEADTIME_CYCLES(8),
        .RAMP_CYCLES    (2),
        .OC_THRESHOLD   (12'd2000),
        .OC_FILTER      (3),
        .COOLDOWN_CYCLES(20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_en       (cmd_en),
        .cmd_dir      (cmd_dir),
        .cmd_speed    (cmd_speed),
        .current_value(current_value),
        .current_valid(current_valid),
        .drive_en     (drive_en),
        .drive_dir    (drive_dir),
        .drive_duty   (drive_duty),
        .fault        (fault),
        .fault_count  (fault_count),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [11:0] val);
        current_value = val;
        current_valid = 1'b1;
        tick();
        current_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; cmd_en = 1'b0; cmd_dir = 1'b0; cmd_speed = 6'd0;
        current_value = 12'd0; current_valid = 1'b0;
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_en", drive_en, 0);
        chk("rst_dir", drive_dir, 0);
        chk("rst_duty", drive_duty, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fcnt", fault_count, 0);
        reset = 1'b0;
        tick();
        chk("idle_hold", state, 0);

        // Soft-start ramp to 5, then immediate step down to 2
        cmd_en = 1'b1; cmd_dir = 1'b0; cmd_speed = 6'd5;
        tick();
        chk("run_enter", state, 1);
        chk("run_en", drive_en, 1);
        chk("run_duty0", drive_duty, 0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("ramp_%0d", k), drive_duty, (k / 2 > 5) ? 5 : k / 2);
        end
        cmd_speed = 6'd2;
        tick();
        chk("step_down", drive_duty, 2);
        cmd_speed = 6'd5;
        repeat (6) tick();
        chk("ramp_back", drive_duty, 5);

        // Reversal through an 8-cycle brake; a mid-brake wobble is ignored
        cmd_dir = 1'b1;
        tick();
        chk("brk_state", state, 2);
        chk("brk_duty", drive_duty, 0);
        chk("brk_en", drive_en, 1);
        chk("brk_dir", drive_dir, 0);
        for (int i = 1; i <= 7; i++) begin
            if (i == 3) cmd_dir = 1'b0;
            if (i == 5) cmd_dir = 1'b1;
            tick();
            chk($sformatf("brk_hold_%0d", i), state, 2);
        end
        tick();
        chk("rev_state", state, 1);
        chk("rev_dir", drive_dir, 1);
        chk("rev_duty", drive_duty, 0);
        tick();
        chk("rev_ramp_a", drive_duty, 0);
        tick();
        chk("rev_ramp_b", drive_duty, 1);

        // Filter: interrupted sequence does not trip; three in a row does
        sample(12'd2500); sample(12'd1000); sample(12'd2500); sample(12'd2500);
        chk("no_trip", state, 1);
        sample(12'd1000);
        sample(12'd2500); sample(12'd2500);
        chk("two_ok", state, 1);
        current_value = 12'd2500; current_valid = 1'b1;
        tick();
        current_valid = 1'b0;
        chk("trip_state", state, 3);
        chk("trip_en", drive_en, 0);
        chk("trip_duty", drive_duty, 0);
        chk("trip_fault", fault, 1);
        chk("trip_fcnt", fault_count, 1);

        // Rearm requires cmd_en low after cooldown
        repeat (40) tick();
        chk("fault_hold", state, 3);
        chk("fault_hold_f", fault, 1);
        cmd_en = 1'b0;
        tick();
        chk("rearm_idle", state, 0);
        chk("rearm_fault", fault, 0);
        cmd_en = 1'b1;
        tick();
        chk("rearm_run", state, 1);
        chk("rearm_dir", drive_dir, 1);

        // Third sample coincides with a direction change
        sample(12'd2500); sample(12'd2500);
        current_value = 12'd2500; current_valid = 1'b1; cmd_dir = 1'b0;
        tick();
        current_valid = 1'b0;
        chk("prio_state", state, 3);
        chk("prio_fcnt", fault_count, 2);
        cmd_en = 1'b0;
        repeat (20) tick();
        chk("prio_idle", state, 0);

        // Reset in the middle of BRAKE
        cmd_en = 1'b1; cmd_dir = 1'b0; cmd_speed = 6'd5;
        tick();
        repeat (4) tick();
        chk("pre_brk_duty", drive_duty, 2);
        cmd_dir = 1'b1;
        tick(); tick(); tick();
        chk("pre_rst_brk", state, 2);
        reset = 1'b1;
        tick();
        chk("mid_rst_state", state, 0);
        chk("mid_rst_en", drive_en, 0);
        chk("mid_rst_dir", drive_dir, 0);
        chk("mid_rst_duty", drive_duty, 0);
        chk("mid_rst_fcnt", fault_count, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_run", state, 1);
        chk("post_rst_dir", drive_dir, 1);
        chk("post_rst_duty", drive_duty, 0);

        // Repeated trips saturate the trip counter; first pass checks cooldown length
        for (int i = 1; i <= 17; i++) begin
            current_value = 12'd3000; current_valid = 1'b1;
            repeat (3) tick();
            current_valid = 1'b0;
            chk($sformatf("sat_state_%0d", i), state, 3);
            chk($sformatf("sat_fcnt_%0d", i), fault_count, (i > 15) ? 15 : i);
            cmd_en = 1'b0;
            repeat (19) tick();
            if (i == 1) chk("cool_min", state, 3);
            tick();
            chk($sformatf("sat_idle_%0d", i), state, 0);
            cmd_en = 1'b1;
            tick();
        end
        chk("sat_final", fault_count, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/motor_sequencer.md
MOTOR_SEQUENCER -- requirements
Module: motor_sequencer

Interface
REQ-001 Parameter DEADTIME_CYCLES, default 100000: dead-time on reversal or stop (1 ms at 100 MHz).
REQ-002 Parameter RAMP_CYCLES, default 200000: cycles per +1 duty step during soft start.
REQ-003 Parameter OC_THRESHOLD, default 12'd2000: overcurrent trip level, in current_value units.
REQ-004 Parameter OC_FILTER, default 16: consecutive over-threshold valid samples needed to trip.
REQ-005 Parameter COOLDOWN_CYCLES, default 50000000: minimum time held in FAULT.
REQ-006 clk  input  1  system clock, 100 MHz; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 cmd_en  input  1  operator run request, e.g. a switch.
REQ-009 cmd_dir  input  1  requested direction (0 forward, 1 reverse).
REQ-010 cmd_speed  input  6  requested duty, 0..63.
REQ-011 current_value  input  12  latest current-sensor reading, unsigned.
REQ-012 current_valid  input  1  one-cycle strobe; current_value is new this cycle.
REQ-013 drive_en  output  1  H-bridge enable.
REQ-014 drive_dir  output  1  direction actually applied to the bridge.
REQ-015 drive_duty  output  6  duty applied to the downstream PWM generator.
REQ-016 fault  output  1  high while in FAULT.
REQ-017 fault_count  output  4  saturating count of overcurrent trips.
REQ-018 state  output  2  IDLE=0, RUN=1, BRAKE=2, FAULT=3.

Function
REQ-019 IDLE: drive_en=0, drive_duty=0. The block moves to RUN when cmd_en=1, latching drive_dir<=cmd_dir and starting at duty 0.
REQ-020 RUN: drive_en=1.
- If cmd_speed > drive_duty, drive_duty increments by 1 once every RAMP_CYCLES cycles.
- If cmd_speed < drive_duty, drive_duty takes cmd_speed on the next cycle (no ramp down).
REQ-021 RUN with cmd_dir != drive_dir: the block goes to BRAKE next cycle, with drive_duty=0 and drive_en=1; drive_dir is held.
REQ-022 RUN with cmd_en=0: the block goes to BRAKE; when BRAKE expires it goes to IDLE.
REQ-023 BRAKE lasts exactly DEADTIME_CYCLES cycles, with drive_duty=0 throughout. On expiry:
- cmd_en=1: go to RUN, drive_dir<=cmd_dir sampled at expiry, ramp restarts from 0.
- cmd_en=0: go to IDLE with drive_en=0.
REQ-024 Direction or enable changes during BRAKE do not restart the dead-time counter; only the value at expiry counts.
REQ-025 Overcurrent filter:
- A 5-bit counter increments on each current_valid with current_value >= OC_THRESHOLD.
- It clears on current_valid with current_value < OC_THRESHOLD.
- It holds when current_valid=0.
- It is active in RUN and BRAKE only and clears in IDLE and FAULT.
REQ-026 When the filter count reaches OC_FILTER, the next cycle is FAULT: drive_en=0, drive_duty=0, fault=1, and fault_count increments, saturating at 15. Overcurrent takes priority over every other transition in the same cycle.
REQ-027 FAULT holds for at least COOLDOWN_CYCLES cycles. The block exits to IDLE only on the first cycle where cooldown has expired and cmd_en=0, so the operator must toggle enable to rearm.
REQ-028 drive_dir never changes while drive_duty != 0; changes happen only on the IDLE->RUN or BRAKE->RUN transition.
REQ-029 All outputs are registered; latency from input to output is 1 cycle.
REQ-030 Counter widths are sized from the parameters ($clog2); no counter wraps.

Reset
REQ-031 While reset=1, on each rising clk edge:
- state=IDLE; drive_en=0; drive_dir=0; drive_duty=0; fault=0; fault_count=0.
- All internal counters are cleared.
REQ-032 Reset asserted mid-RUN, mid-BRAKE or mid-FAULT forces IDLE on the next edge. After release, cmd_en=1 enters RUN at duty 0 with no dead-time.

Verification (DEADTIME_CYCLES=8, RAMP_CYCLES=2, OC_FILTER=3, COOLDOWN_CYCLES=20)
REQ-033 Ramp: reset, then cmd_en=1, cmd_dir=0, cmd_speed=5 -> RUN; drive_duty steps 0,1,...,5, one step per 2 cycles, then holds at 5. Setting cmd_speed=2 -> drive_duty=2 on the next cycle.
REQ-034 Reversal: in RUN at duty 5, set cmd_dir=1 -> BRAKE for exactly 8 cycles with duty 0 and drive_dir=0, then RUN with drive_dir=1 and the ramp restarting from 0.
REQ-035 Trip: in RUN, three consecutive valid samples of 2500 -> FAULT, drive_en=0, fault=1, fault_count=1. A sample sequence 2500, 1000, 2500, 2500 does not trip.
REQ-036 Rearm: in FAULT with cmd_en held at 1 for 40 cycles -> the block stays in FAULT. Dropping cmd_en=0 after cooldown -> IDLE; cmd_en=1 -> RUN.
REQ-037 Priority and reset: the third over-threshold sample arriving in the same cycle as a cmd_dir change -> FAULT, not BRAKE. Asserting reset during BRAKE -> IDLE and all outputs 0 on the next edge.
REQ-038 Saturation: 17 forced trips -> fault_count stays at 15.
